// File: rtl/ahb_arbiter_np_if.sv
// ahb_arbiter_np_if: AHB arbitration signals shared by the masters (requesters) and the arbiter
interface ahb_arbiter_np_if #(
  parameter int NUM_MST = 4,
  parameter int MW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
);
  logic [NUM_MST-1:0] HBUSREQ;
  logic [NUM_MST-1:0] HLOCK;
  logic [1:0]         HTRANS;
  logic [2:0]         HBURST;
  logic               HREADY;
  logic [NUM_MST-1:0] HGRANT;
  logic [MW-1:0]      HMASTER;
  logic               HMASTLOCK;
  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter_np.sv
// ahb_arbiter_np: AHB bus arbiter, fixed-priority or round-robin, burst/lock aware; AHB_ARB_MAXHOLD_EN enables the starvation guard
module ahb_arbiter_np #(
  parameter int NUM_MST  = 4,
  parameter int ARB_MODE = 0,
  parameter int DEF_MST  = 0,
  parameter int MAX_HOLD = 16,
  localparam int MW      = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_arbiter_np_if.slave bus
);
  localparam logic [NUM_MST-1:0] DEF_OH = {{(NUM_MST-1){1'b0}}, 1'b1} << DEF_MST;
  logic [NUM_MST-1:0] grant, req, win_oh;
  logic [MW-1:0]      owner, winner, master_q, rr_ptr;
  logic               lock_q, arb_ok;
  logic [4:0]         beats_left, next_beats, len;
  // owner is the master currently holding the one-hot grant
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MST; i++)
      if (grant[i]) owner = MW'(i);
  end
  assign len = (bus.HBURST inside {3'd2, 3'd3}) ? 5'd3 :
               (bus.HBURST inside {3'd4, 3'd5}) ? 5'd7 :
               (bus.HBURST inside {3'd6, 3'd7}) ? 5'd15 : 5'd0;
  assign next_beats = !bus.HREADY ? beats_left :
                      (bus.HTRANS == 2'b10) ? len :
                      (bus.HTRANS == 2'b11 && beats_left != 5'd0) ? beats_left - 5'd1 :
                      (bus.HTRANS == 2'b00) ? 5'd0 : beats_left;
  assign arb_ok = bus.HREADY && next_beats == 5'd0 && !lock_q && !bus.HLOCK[owner];
`ifdef AHB_ARB_MAXHOLD_EN
  logic [4:0] hold_cnt, hold_inc;
  logic       mask;
  assign hold_inc = (bus.HREADY && bus.HTRANS[1] && hold_cnt != 5'd31) ? hold_cnt + 5'd1 : hold_cnt;
  assign mask     = int'(hold_inc) >= MAX_HOLD && |(bus.HBUSREQ & ~grant);
  assign req      = bus.HBUSREQ & ~(mask ? grant : '0);
  // transfers since the owner was granted; restarts whenever ownership changes or the owner is masked
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) hold_cnt <= '0;
    else if (arb_ok && (mask || winner != owner)) hold_cnt <= '0;
    else hold_cnt <= hold_inc;
`else
  logic unused_hold;
  assign unused_hold = ^MAX_HOLD;
  assign req = bus.HBUSREQ;
`endif
  // winner: lowest index, or first index above rr_ptr with wrap; default master when idle
  always_comb begin
    int best, d;
    best   = NUM_MST;
    winner = MW'(DEF_MST);
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      d = (ARB_MODE == 0) ? i : (i - int'(rr_ptr) - 1 + 2 * NUM_MST) % NUM_MST;
      if (req[i] && d <= best) begin
        best   = d;
        winner = MW'(i);
      end
    end
    win_oh = '0;
    win_oh[winner] = 1'b1;
  end
  // grant moves only at arbitration points; address-phase owner and lock follow on accepted cycles
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      grant      <= DEF_OH;
      master_q   <= MW'(DEF_MST);
      lock_q     <= 1'b0;
      beats_left <= '0;
      rr_ptr     <= MW'(DEF_MST);
    end else begin
      beats_left <= next_beats;
      if (bus.HREADY) begin
        master_q <= owner;
        lock_q   <= bus.HLOCK[owner];
      end
      if (arb_ok) begin
        grant <= win_oh;
        if (|req) rr_ptr <= winner;
      end
    end
  assign bus.HGRANT    = grant;
  assign bus.HMASTER   = master_q;
  assign bus.HMASTLOCK = lock_q;
endmodule

// File: tb/tb_ahb_arbiter_np.sv
// tb_ahb_arbiter_np: directed checks of a fixed-priority and a round-robin arbiter instance
module tb_ahb_arbiter_np;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ahb_arbiter_np_if #(.NUM_MST(4)) ifp ();
  ahb_arbiter_np_if #(.NUM_MST(4)) irr ();
  ahb_arbiter_np #(.NUM_MST(4), .ARB_MODE(0), .DEF_MST(2), .MAX_HOLD(4)) dut_fp (
    .HCLK(clk), .HRESETn(rst_n), .bus(ifp)
  );
  ahb_arbiter_np #(.NUM_MST(4), .ARB_MODE(1), .DEF_MST(0), .MAX_HOLD(16)) dut_rr (
    .HCLK(clk), .HRESETn(rst_n), .bus(irr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [3:0]  rr_exp [5];
  logic [10:0] rdy_v;
  initial begin
    rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rdy_v  = 11'b11101101101;
    ifp.HBUSREQ = '0; ifp.HLOCK = '0; ifp.HTRANS = IDLE; ifp.HBURST = 3'b000; ifp.HREADY = 1'b1;
    irr.HBUSREQ = '0; irr.HLOCK = '0; irr.HTRANS = IDLE; irr.HBURST = 3'b000; irr.HREADY = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(ifp.HGRANT), 32'b0100);
    chk("rst_master", 32'(ifp.HMASTER), 32'd2);
    chk("rst_lock", 32'(ifp.HMASTLOCK), 32'd0);
    chk("rst_rr_grant", 32'(irr.HGRANT), 32'b0001);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_grant", 32'(ifp.HGRANT), 32'b0100);
    chk("idle_master", 32'(ifp.HMASTER), 32'd2);
    chk("idle_lock", 32'(ifp.HMASTLOCK), 32'd0);
    // fixed priority: master 1 beats master 3 until it drops its request
    ifp.HBUSREQ = 4'b1010; ifp.HTRANS = NONSEQ;
    tick();
    chk("fp_grant_m1", 32'(ifp.HGRANT), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fp_hold_m1", 32'(ifp.HGRANT), 32'b0010);
      chk("fp_master_m1", 32'(ifp.HMASTER), 32'd1);
    end
    ifp.HBUSREQ = 4'b1000;
    tick();
    chk("fp_grant_m3", 32'(ifp.HGRANT), 32'b1000);
    tick();
    chk("fp_master_m3", 32'(ifp.HMASTER), 32'd3);
    ifp.HBUSREQ = '0; ifp.HTRANS = IDLE;
    tick();
    chk("fp_back_def", 32'(ifp.HGRANT), 32'b0100);
    // round robin rotation from rr_ptr=0
    irr.HBUSREQ = 4'b1111; irr.HTRANS = NONSEQ;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_order%0d", i), 32'(irr.HGRANT), 32'(rr_exp[i]));
    end
    irr.HBUSREQ = '0; irr.HTRANS = IDLE;
    // INCR8 from master 0 with three wait states; master 1 requests from beat 2
    ifp.HBUSREQ = 4'b0001;
    tick();
    chk("burst_grant_m0", 32'(ifp.HGRANT), 32'b0001);
    tick();
    chk("burst_master_m0", 32'(ifp.HMASTER), 32'd0);
    ifp.HBURST = 3'b101;
    for (int i = 0; i < 11; i++) begin
      ifp.HTRANS = (i == 0) ? NONSEQ : SEQ;
      ifp.HREADY = rdy_v[i];
      if (i == 1) ifp.HBUSREQ = 4'b0010;
      tick();
      chk($sformatf("burst_grant%0d", i), 32'(ifp.HGRANT), (i == 10) ? 32'b0010 : 32'b0001);
      chk($sformatf("burst_master%0d", i), 32'(ifp.HMASTER), 32'd0);
    end
    ifp.HTRANS = IDLE; ifp.HBURST = 3'b000; ifp.HBUSREQ = '0;
    tick();
    chk("burst_after_m1", 32'(ifp.HMASTER), 32'd1);
    tick();
    chk("burst_def", 32'(ifp.HGRANT), 32'b0100);
    chk("burst_def_master", 32'(ifp.HMASTER), 32'd2);
    // locked pair of SINGLE transfers from master 2 with master 0 requesting
    ifp.HLOCK = 4'b0100; ifp.HBUSREQ = 4'b0101;
    tick();
    chk("lock_grant1", 32'(ifp.HGRANT), 32'b0100);
    chk("lock_hml1", 32'(ifp.HMASTLOCK), 32'd1);
    ifp.HTRANS = NONSEQ;
    tick();
    chk("lock_grant2", 32'(ifp.HGRANT), 32'b0100);
    chk("lock_hml2", 32'(ifp.HMASTLOCK), 32'd1);
    ifp.HLOCK = '0; ifp.HBUSREQ = 4'b0001;
    tick();
    chk("lock_grant3", 32'(ifp.HGRANT), 32'b0100);
    chk("lock_hml3", 32'(ifp.HMASTLOCK), 32'd0);
    ifp.HTRANS = IDLE;
    tick();
    chk("lock_release", 32'(ifp.HGRANT), 32'b0001);
    ifp.HBUSREQ = '0;
    tick();
    chk("lock_def", 32'(ifp.HGRANT), 32'b0100);
    // hold limit with masters 0 and 1 requesting
    ifp.HBUSREQ = 4'b0011;
    tick();
    chk("hold_grant_m0", 32'(ifp.HGRANT), 32'b0001);
    tick();
    ifp.HTRANS = NONSEQ;
    for (int i = 1; i <= 4; i++) begin
      tick();
`ifdef AHB_ARB_MAXHOLD_EN
      chk($sformatf("hold_t%0d", i), 32'(ifp.HGRANT), (i == 4) ? 32'b0010 : 32'b0001);
`else
      chk($sformatf("hold_t%0d", i), 32'(ifp.HGRANT), 32'b0001);
`endif
    end
    ifp.HTRANS = IDLE;
    tick();
    chk("hold_regain_m0", 32'(ifp.HGRANT), 32'b0001);
`ifndef AHB_ARB_MAXHOLD_EN
    ifp.HTRANS = NONSEQ;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_forever_m0", 32'(ifp.HGRANT), 32'b0001);
    end
`endif
    // asynchronous reset in the middle of an INCR16 from master 0
    ifp.HBUSREQ = 4'b0001; ifp.HTRANS = NONSEQ; ifp.HBURST = 3'b111;
    tick();
    ifp.HTRANS = SEQ;
    tick();
    chk("mid_burst_grant", 32'(ifp.HGRANT), 32'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(ifp.HGRANT), 32'b0100);
    chk("async_master", 32'(ifp.HMASTER), 32'd2);
    chk("async_lock", 32'(ifp.HMASTLOCK), 32'd0);
    ifp.HBUSREQ = '0; ifp.HTRANS = IDLE; ifp.HBURST = 3'b000;
    tick();
    rst_n = 1'b1;
    ifp.HBUSREQ = 4'b1000; ifp.HTRANS = 2'b01;
    tick();
    chk("post_rst_arb", 32'(ifp.HGRANT), 32'b1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
